// File: rtl/mux2_rr_arbiter.sv
// ============================================================================
// Module   : mux2_rr_arbiter
// Brief    : Round-robin arbiter and sequencer for a shared 2:1 mux. Grants
//            one of two requesters, owns the mux select, and hands the
//            selected word to one consumer over a valid/ready handshake.
//            Optional stall-limit grant revocation: MUX2_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux2_rr_arbiter #(
  parameter int WIDTH   = 2,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [7:0]       xfer_cnt,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  // last_q encoding: 0 = A served most recently, 1 = B served most recently
  state_t     state_q, state_d;
  logic       last_q, last_d;
  logic       sel_q, sel_d;
  logic [7:0] xfer_cnt_q, xfer_cnt_d;

  logic       own_req;
  logic       owner;
  logic       xfer;

  // Pick the next owner from the live requests; a tie goes to the side
  // that was not served last.
  function automatic state_t arbitrate(input logic ra, input logic rb,
                                       input logic lst);
    if (ra && rb)  return lst ? GNT_A : GNT_B;
    else if (ra)   return GNT_A;
    else if (rb)   return GNT_B;
    else           return IDLE;
  endfunction

  assign gnt_a     = (state_q == GNT_A);
  assign gnt_b     = (state_q == GNT_B);
  assign sel       = sel_q;
  assign out_valid = (gnt_a & req_a) | (gnt_b & req_b);
  assign out_data  = sel_q ? data_b : data_a;
  assign xfer_cnt  = xfer_cnt_q;
  assign xfer      = out_valid & out_ready;
  assign owner     = gnt_b;
  assign own_req   = gnt_b ? req_b : req_a;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIM = TIMEOUT[7:0];

  logic [7:0] stall_q, stall_d;
  logic       timeout_q, timeout_d;

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT > 0);
  assign timeout            = 1'b0;
`endif

  // Next-state, pointer, counter and select computation
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    xfer_cnt_d = xfer_cnt_q;
`ifdef MUX2_ARB_TIMEOUT_EN
    stall_d    = 8'd0;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        state_d = arbitrate(req_a, req_b, last_q);
      end
      GNT_A, GNT_B: begin
        if (xfer) begin
          xfer_cnt_d = xfer_cnt_q + 8'd1;
          last_d     = owner;
          state_d    = arbitrate(req_a, req_b, owner);
        end else if (!own_req) begin
          // requester withdrew before handing its word over
          state_d = IDLE;
`ifdef MUX2_ARB_TIMEOUT_EN
        end else if ((stall_q + 8'd1) == TIMEOUT_LIM) begin
          // stalled consumer: revoke and let the other side go first
          state_d   = IDLE;
          last_d    = owner;
          timeout_d = 1'b1;
        end else begin
          stall_d = stall_q + 8'd1;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // select follows the owner; it is left alone while idle
    if (state_d == GNT_B)      sel_d = 1'b1;
    else if (state_d == GNT_A) sel_d = 1'b0;
    else                       sel_d = sel_q;
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      xfer_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

`ifdef MUX2_ARB_TIMEOUT_EN
  // Stall counter and timeout pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q   <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux2_rr_arbiter.sv
// ============================================================================
// Module   : tb_mux2_rr_arbiter
// Brief    : Self-checking bench for mux2_rr_arbiter: a vector table for the
//            cycle-by-cycle behaviour plus directed multi-cycle sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b, out_ready;
  logic [1:0] data_a, data_b;
  logic       gnt_a, gnt_b, sel, out_valid, timeout;
  logic [1:0] out_data;
  logic [7:0] xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MUX2_ARB_TIMEOUT_EN
  localparam int STALL_N = 2;
`else
  localparam int STALL_N = 5;
`endif

  mux2_rr_arbiter #(.WIDTH(2), .TIMEOUT(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_a    (req_a),
    .data_a   (data_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .sel      (sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .xfer_cnt (xfer_cnt),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // inputs for one cycle and the outputs expected during that cycle
  // exp = {gnt_a, gnt_b, sel, out_valid, out_data[1:0], xfer_cnt[7:0]}
  typedef struct {
    logic       ra;
    logic [1:0] da;
    logic       rb;
    logic [1:0] db;
    logic       rdy;
    logic [13:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ra, input logic [1:0] da,
                              input logic rb, input logic [1:0] db,
                              input logic rdy, input logic ga,
                              input logic gb, input logic s, input logic v,
                              input logic [1:0] d, input logic [7:0] c);
    vec_t r;
    r.ra = ra; r.da = da; r.rb = rb; r.db = db; r.rdy = rdy;
    r.exp = {ga, gb, s, v, d, c};
    return r;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    data_a = 2'b00; data_b = 2'b00;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = mk(1, 2'b10, 0, 2'b11, 1,  0, 0, 0, 0, 2'b10, 8'd0);
    vecs[1]  = mk(1, 2'b10, 0, 2'b11, 1,  1, 0, 0, 1, 2'b10, 8'd0);
    vecs[2]  = mk(0, 2'b10, 0, 2'b11, 1,  1, 0, 0, 0, 2'b10, 8'd1);
    vecs[3]  = mk(1, 2'b01, 1, 2'b11, 1,  0, 0, 0, 0, 2'b01, 8'd1);
    vecs[4]  = mk(1, 2'b01, 1, 2'b11, 1,  0, 1, 1, 1, 2'b11, 8'd1);
    vecs[5]  = mk(1, 2'b01, 1, 2'b11, 1,  1, 0, 0, 1, 2'b01, 8'd2);
    vecs[6]  = mk(1, 2'b01, 1, 2'b11, 0,  0, 1, 1, 1, 2'b11, 8'd3);
    vecs[7]  = mk(1, 2'b01, 1, 2'b11, 0,  0, 1, 1, 1, 2'b11, 8'd3);
    vecs[8]  = mk(1, 2'b01, 0, 2'b11, 0,  0, 1, 1, 0, 2'b11, 8'd3);
    vecs[9]  = mk(1, 2'b01, 0, 2'b11, 0,  0, 0, 1, 0, 2'b11, 8'd3);
    vecs[10] = mk(1, 2'b01, 0, 2'b11, 1,  1, 0, 0, 1, 2'b01, 8'd3);
    vecs[11] = mk(0, 2'b01, 0, 2'b11, 1,  1, 0, 0, 0, 2'b01, 8'd4);
    vecs[12] = mk(0, 2'b01, 0, 2'b11, 1,  0, 0, 0, 0, 2'b01, 8'd4);

    // reset state
    do_reset();
    #1;
    check("reset_outputs", {gnt_a, gnt_b, sel, out_valid, timeout, xfer_cnt},
          {5'b00000, 8'd0});

    // vector table
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      req_a = vecs[i].ra; data_a = vecs[i].da;
      req_b = vecs[i].rb; data_b = vecs[i].db;
      out_ready = vecs[i].rdy;
      #1;
      check($sformatf("vec%0d", i),
            {gnt_a, gnt_b, sel, out_valid, out_data, xfer_cnt}, vecs[i].exp);
    end

    // first tie after reset: A, B, A, B back to back
    @(negedge clk);
    do_reset();
    req_a = 1'b1; req_b = 1'b1; data_a = 2'b10; data_b = 2'b01;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("tie_grant%0d", k), {gnt_a, gnt_b, out_valid},
            (k % 2 == 0) ? 3'b101 : 3'b011);
      check($sformatf("tie_data%0d", k), out_data,
            (k % 2 == 0) ? 2'b10 : 2'b01);
    end
    @(negedge clk);
    #1;
    check("tie_count", {gnt_a, xfer_cnt}, {1'b1, 8'd4});

    // A transfers this cycle, then B is stalled by the consumer
    @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < STALL_N; k++) begin
      #1;
      check($sformatf("stall%0d", k), {gnt_b, out_valid, out_data, xfer_cnt},
            {1'b1, 1'b1, 2'b01, 8'd5});
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    check("stall_release", {gnt_a, gnt_b, xfer_cnt}, {2'b10, 8'd6});

    // asynchronous reset between edges while A is granted
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {gnt_a, gnt_b, out_valid, xfer_cnt},
          {3'b000, 8'd0});
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0; out_ready = 1'b0;
    reset = 1'b0;

    // stalled grant to A with B waiting
    req_a = 1'b1;
    @(negedge clk);
    #1;
    check("to_grant_a", {gnt_a, timeout}, 2'b10);
    req_b = 1'b1;
`ifdef MUX2_ARB_TIMEOUT_EN
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("to_wait%0d", k), {gnt_a, gnt_b, timeout}, 3'b100);
    end
    @(negedge clk);
    #1;
    check("to_pulse", {gnt_a, gnt_b, timeout, xfer_cnt}, {3'b001, 8'd0});
    @(negedge clk);
    #1;
    check("to_then_b", {gnt_a, gnt_b, timeout, sel}, 4'b0101);
`else
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("no_to%0d", k), {gnt_a, gnt_b, timeout}, 3'b100);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
